// File: rtl/alu_pkg.sv
// Shared constants and types for the round-robin ALU arbiter.
// Optional subtract support is enabled by the ALU_ARB_SUB_EN macro.
package alu_pkg;

  localparam int unsigned W      = 16;
  localparam int unsigned NFLAGS = 5;

  localparam int unsigned FLAG_SIGN   = 0;
  localparam int unsigned FLAG_ZERO   = 1;
  localparam int unsigned FLAG_CARRY  = 2;
  localparam int unsigned FLAG_PARITY = 3;
  localparam int unsigned FLAG_OVF    = 4;

  typedef logic [W-1:0]      word_t;
  typedef logic [NFLAGS-1:0] flags_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and result bundle of the ALU arbiter; req_op exists only with ALU_ARB_SUB_EN.
// The slave modport is the arbiter side, master is the client/consumer side.
interface alu_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*alu_pkg::W-1:0]  req_x;
  logic [NREQ*alu_pkg::W-1:0]  req_y;
`ifdef ALU_ARB_SUB_EN
  logic [NREQ-1:0]             req_op;
`endif
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [alu_pkg::W-1:0]       rsp_z;
  logic [alu_pkg::NFLAGS-1:0]  rsp_flags;

`ifdef ALU_ARB_SUB_EN
  modport slave (
    input  req_valid, req_x, req_y, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags
  );

  modport master (
    output req_valid, req_x, req_y, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags
  );
`else
  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags
  );
`endif

endinterface

// File: rtl/alu_core.sv
// Combinational 16-bit adder with sign/zero/carry/parity/overflow flags.
// With ALU_ARB_SUB_EN, op_i=1 selects x + ~y + 1 (carry=1 means no borrow).
module alu_core
  import alu_pkg::*;
(
  input  word_t  x_i,
  input  word_t  y_i,
`ifdef ALU_ARB_SUB_EN
  input  logic   op_i,
`endif
  output word_t  z_o,
  output flags_t flags_o
);

  word_t        y_eff;
  logic         cin;
  logic [W:0]   sum;

  always_comb begin
`ifdef ALU_ARB_SUB_EN
    y_eff = op_i ? ~y_i : y_i;
    cin   = op_i;
`else
    y_eff = y_i;
    cin   = 1'b0;
`endif
    sum = {1'b0, x_i} + {1'b0, y_eff} + {{W{1'b0}}, cin};
  end

  always_comb begin
    z_o                  = sum[W-1:0];
    flags_o              = '0;
    flags_o[FLAG_SIGN]   = sum[W-1];
    flags_o[FLAG_ZERO]   = (sum[W-1:0] == '0);
    flags_o[FLAG_CARRY]  = sum[W];
    flags_o[FLAG_PARITY] = ~^sum[W-1:0];
    // Comparing against the effective y covers both the add and subtract overflow rules.
    flags_o[FLAG_OVF]    = (x_i[W-1] == y_eff[W-1]) & (sum[W-1] != x_i[W-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core among NREQ requesters, one operation at a time.
// Optional subtract operation is compiled in with ALU_ARB_SUB_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  word_t           x_q, y_q;
`ifdef ALU_ARB_SUB_EN
  logic            op_q;
`endif
  logic [IDW-1:0]  rsp_id_q;
  word_t           rsp_z_q;
  flags_t          rsp_flags_q;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic            accept;
  word_t           core_z;
  flags_t          core_flags;

  // Search starts just after the last served requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    accept        = (state_q == IDLE) && grant_found && !rst;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = EXEC;
      EXEC:                       state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  alu_core u_core (
    .x_i     (x_q),
    .y_i     (y_q),
`ifdef ALU_ARB_SUB_EN
    .op_i    (op_q),
`endif
    .z_o     (core_z),
    .flags_o (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      x_q         <= '0;
      y_q         <= '0;
`ifdef ALU_ARB_SUB_EN
      op_q        <= 1'b0;
`endif
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= grant_idx;
        x_q   <= bus.req_x[grant_idx*W +: W];
        y_q   <= bus.req_y[grant_idx*W +: W];
`ifdef ALU_ARB_SUB_EN
        op_q  <= bus.req_op[grant_idx];
`endif
      end
      // ptr_q still names the accepted requester while in EXEC.
      if (state_q == EXEC) begin
        rsp_id_q    <= ptr_q;
        rsp_z_q     <= core_z;
        rsp_flags_q <= core_flags;
      end
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_flags = rsp_flags_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected results, a monitor pops and checks.
// Subtract vectors run only when ALU_ARB_SUB_EN is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    z;
    logic [4:0]     flags;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic push(input int id, input logic [15:0] z, input logic [4:0] f);
    exp_t e;
    e.id    = IDW'(id);
    e.z     = z;
    e.flags = f;
    sb.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [15:0] x, input logic [15:0] y);
    bus.req_x[id*16 +: 16] = x;
    bus.req_y[id*16 +: 16] = y;
  endtask

  // Wait for the grant to requester id, let the edge accept it, then drop its valid.
  task automatic wait_grant(input int id, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[id] === 1'b1) got = 1'b1;
    end
    if (!got) fail_now(name);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                       input string name);
    set_req(id, x, y);
    bus.req_valid[id] = 1'b1;
    wait_grant(id, name);
  endtask

  task automatic wait_accepts(input int n, input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40 * n && cnt < n; i++) begin
      @(negedge clk);
      if (bus.req_ready !== '0) cnt++;
    end
    if (cnt < n) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: first cycle of each response pops the scoreboard; later cycles check it holds.
  initial begin : monitor
    exp_t cur;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got id=%0d z=%h, expected no response",
                     bus.rsp_id, bus.rsp_z);
          end else begin
            cur  = sb.pop_front();
            seen = 1'b1;
            check("rsp_id", 32'(bus.rsp_id), 32'(cur.id));
            check("rsp_z", 32'(bus.rsp_z), 32'(cur.z));
            check("rsp_flags", 32'(bus.rsp_flags), 32'(cur.flags));
          end
        end else begin
          check("hold_id", 32'(bus.rsp_id), 32'(cur.id));
          check("hold_z", 32'(bus.rsp_z), 32'(cur.z));
          check("hold_flags", 32'(bus.rsp_flags), 32'(cur.flags));
        end
        if (bus.rsp_ready === 1'b1) seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_x     = '0;
    bus.req_y     = '0;
`ifdef ALU_ARB_SUB_EN
    bus.req_op    = '0;
`endif
    bus.rsp_ready = 1'b0;

    // 1: reset with every requester valid
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
      check("rst_rsp_z", 32'(bus.rsp_z), 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("first_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;

    // 2: 0x7FFF + 1 overflows into the sign bit
    bus.rsp_ready = 1'b1;
    push(0, 16'h8000, 5'b10001);
    issue(0, 16'h7FFF, 16'h0001, "accept_t2");
    check("lat_exec_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    check("lat_resp_valid", 32'(bus.rsp_valid), 32'h1);

    // 3: wrap to zero, then hold the result under backpressure
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    push(0, 16'h0000, 5'b01110);
    issue(0, 16'hFFFF, 16'h0001, "accept_t3");
    set_req(2, 16'h1234, 16'h1111);
    bus.req_valid[2] = 1'b1;
    push(2, 16'h2345, 5'b01000);
    repeat (5) begin
      @(negedge clk);
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_grant(2, "accept_after_bp");

    // 4: all four requesters contending, then only 1 and 2
    do_reset();
    set_req(0, 16'h1000, 16'h0001);
    set_req(1, 16'h2000, 16'h0002);
    set_req(2, 16'h3000, 16'h0003);
    set_req(3, 16'hC000, 16'h4004);
    push(0, 16'h1001, 5'b01000);
    push(1, 16'h2002, 5'b01000);
    push(2, 16'h3003, 5'b01000);
    push(3, 16'h0004, 5'b00100);
    push(0, 16'h1001, 5'b01000);
    push(1, 16'h2002, 5'b01000);
    bus.req_valid = 4'b1111;
    wait_accepts(6, "rr_all");
    bus.req_valid = 4'b0110;
    push(2, 16'h3003, 5'b01000);
    push(1, 16'h2002, 5'b01000);
    wait_accepts(2, "rr_pair");
    bus.req_valid = '0;

    // 5: reset while a result is pending restores the pointer
    repeat (4) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    push(1, 16'h0003, 5'b01000);
    issue(1, 16'h0001, 16'h0002, "accept_t5");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_mid_z", 32'(bus.rsp_z), 32'h0);
    check("rst_mid_id", 32'(bus.rsp_id), 32'h0);
    set_req(0, 16'h00FF, 16'h0001);
    set_req(2, 16'h8000, 16'h8000);
    bus.req_valid = 4'b0101;
    #1;
    check("rst_mid_grant", 32'(bus.req_ready), 32'h1);
    push(0, 16'h0100, 5'b00000);
    push(2, 16'h0000, 5'b11110);
    bus.rsp_ready = 1'b1;
    wait_accepts(2, "rst_mid_pair");
    bus.req_valid = '0;

`ifdef ALU_ARB_SUB_EN
    // 6: subtract
    bus.req_op = 4'b0011;
    push(0, 16'hFFFF, 5'b01001);
    issue(0, 16'h0000, 16'h0001, "accept_sub0");
    push(1, 16'h7FFF, 5'b10100);
    issue(1, 16'h8000, 16'h0001, "accept_sub1");
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
